ft245_fifo_if: RTL
==================

# ft245_fifo_if

Byte-transfer engine for the FT245-style USB FIFO on the Kolibri I/O board: the FIFO-side initiator that drives the chip's RD#/WR strobes and data bus, paired with a 6809-facing data/status register pair. Status bits and polling on the CPU side stay as the bus already expects; this block moves bytes between one-byte RX/TX holding registers and the FIFO chip. It sits behind the I/O address decoder and contributes an active-high interrupt request to the board's IRQ merge.

## Interface
- RD_PULSE, 4: cycles nRD is held low; FD_IN sampled on the last of them (1..15)
- WR_PULSE, 4: cycles WR is held high (1..15)
- RECOVERY, 3: idle cycles after any transfer before the next may start (≥3, covers the 2-flop status sync lag)
- E  in  1  clock, all logic on rising edge
- RES  in  1  reset, synchronous, active-high
- RD_STB  in  1  one-cycle CPU read strobe (decoded)
- WR_STB  in  1  one-cycle CPU write strobe (decoded)
- ADDR  in  1  0 = data register, 1 = status/control register
- DIN  in  8  CPU write data
- DOUT  out  8  CPU read data, combinational from ADDR and registers
- IRQ  out  1  active-high: RXAV & IRQEN
- nRXF  in  1  FIFO has data when low (asynchronous)
- TXE  in  1  FIFO full when high (asynchronous)
- nRD  out  1  FIFO read strobe, active low
- WR  out  1  FIFO write strobe, data latched by chip on falling edge
- FD_IN  in  8  FIFO data bus, input side
- FD_OUT  out  8  FIFO data bus, output side
- FD_OE  out  1  drive enable for FD_OUT

## Operation
- nRXF and TXE pass through 2-flop synchronizers; all decisions use synchronized values.
- Registers: RXHOLD[7:0], RXAV, TXHOLD[7:0], TXFULL, TXOVR (sticky), IRQEN.
- Status read (ADDR=1): bit7 RXAV, bit6 ~TXFULL, bit4 TXOVR, bit0 IRQEN, others 0. RD_STB at ADDR=1 clears TXOVR.
- Control write (ADDR=1): bit0 → IRQEN; other bits ignored.
- Data read (ADDR=0): DOUT=RXHOLD; RD_STB clears RXAV. Read while RXAV=0 returns stale RXHOLD, no side effect.
- Data write (ADDR=0): if TXFULL=0, TXHOLD←DIN, TXFULL←1; else byte dropped, TXOVR←1.
- FSM states: IDLE, RD_LOW, WR_SETUP, WR_HIGH, WR_HOLD, REC.
- IDLE: RX eligible = ~RXAV & ~nRXF_s; TX eligible = TXFULL & ~TXE_s. One eligible → serve it. Both → serve opposite of last served (flag reset to "TX last", so RX wins first tie).
- RX: IDLE→RD_LOW (nRD=0) for RD_PULSE cycles; on last cycle RXHOLD←FD_IN, RXAV←1; →REC.
- TX: IDLE→WR_SETUP: FD_OUT←TXHOLD, FD_OE=1, TXFULL←0 (CPU write that same cycle sees TXFULL=1 → dropped, TXOVR). →WR_HIGH (WR=1) WR_PULSE cycles →WR_HOLD (WR=0, FD_OE=1) 1 cycle →REC, FD_OE=0.
- REC: RECOVERY cycles all strobes inactive, then IDLE.

## Timing
- Reset values: nRD=1, WR=0, FD_OE=0, FD_OUT=0, DOUT per cleared regs, IRQ=0; RXAV=TXFULL=TXOVR=IRQEN=0; FSM=IDLE; synchronizers =1 (nRXF) / 1 (TXE).
- RES mid-transfer: strobes deasserted and FD_OE dropped at the next edge; in-flight byte discarded.
- nRXF falling → nRD low earliest 3 edges later (2 sync + IDLE decision).
- RX cycle length: RD_PULSE + RECOVERY; RXAV visible the cycle after the last RD_LOW cycle.
- TX cycle length: 1 + WR_PULSE + 1 + RECOVERY; FD_OUT stable from WR_SETUP through WR_HOLD.
- IRQ is registered-path combinational (RXAV & IRQEN), updates same cycle those change.
- nRD and WR never active together; FD_OE never high while nRD low.

## Test plan
- Reset then hold nRXF=0, FD_IN=0xA5 → nRD low exactly 4 cycles starting 3 edges after sync, status=0xC0, data read returns 0xA5, status back to 0x40.
- IRQEN=1 written, byte received → IRQ=1; data read → IRQ=0 next cycle; IRQEN=0 masks IRQ with RXAV=1.
- Write 0x3C, TXE=0 → FD_OE high, FD_OUT=0x3C through 1+4+1 cycles, WR high 4 cycles; second write during WR_HIGH accepted (TXFULL was cleared).
- TXE=1 held, write 0x11 then 0x22 → 0x22 dropped, status bit4 set, cleared after status read; 0x11 sent when TXE→0.
- nRXF=0 and TX pending simultaneously → RX first, then TX, then RX alternating; no overlap, RECOVERY gaps of 3.
- RES asserted mid WR_HIGH → WR=0, FD_OE=0 next edge, TXFULL=0, no further strobes.

Source files
------------

// File: rtl/ft245_fifo_if.sv
// ft245_fifo_if: FT245-style USB FIFO initiator with a 6809-facing data/status register pair.
// Revision 1.0 - initial release
`timescale 1ns/1ps
`default_nettype none

module ft245_fifo_if #(
  parameter int unsigned RD_PULSE = 4,
  parameter int unsigned WR_PULSE = 4,
  parameter int unsigned RECOVERY = 3
) (
  input  logic       E,
  input  logic       RES,
  input  logic       RD_STB,
  input  logic       WR_STB,
  input  logic       ADDR,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       IRQ,
  input  logic       nRXF,
  input  logic       TXE,
  output logic       nRD,
  output logic       WR,
  input  logic [7:0] FD_IN,
  output logic [7:0] FD_OUT,
  output logic       FD_OE
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_LOW   = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_HIGH  = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_REC      = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_tx_q, last_tx_d;
  logic               nrxf_meta_q, nrxf_sync_q;
  logic               txe_meta_q, txe_sync_q;
  logic [7:0]         rx_hold_q, rx_hold_d;
  logic               rx_av_q, rx_av_d;
  logic [7:0]         tx_hold_q, tx_hold_d;
  logic               tx_full_q, tx_full_d;
  logic               tx_ovr_q, tx_ovr_d;
  logic               irq_en_q, irq_en_d;
  logic               nrd_q, nrd_d;
  logic               wr_q, wr_d;
  logic               fd_oe_q, fd_oe_d;
  logic [7:0]         fd_out_q, fd_out_d;

  logic               rx_elig;
  logic               tx_elig;

  always_ff @(posedge E) begin
    if (RES) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_tx_q   <= 1'b1;
      nrxf_meta_q <= 1'b1;
      nrxf_sync_q <= 1'b1;
      txe_meta_q  <= 1'b1;
      txe_sync_q  <= 1'b1;
      rx_hold_q   <= '0;
      rx_av_q     <= 1'b0;
      tx_hold_q   <= '0;
      tx_full_q   <= 1'b0;
      tx_ovr_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      nrd_q       <= 1'b1;
      wr_q        <= 1'b0;
      fd_oe_q     <= 1'b0;
      fd_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_tx_q   <= last_tx_d;
      nrxf_meta_q <= nRXF;
      nrxf_sync_q <= nrxf_meta_q;
      txe_meta_q  <= TXE;
      txe_sync_q  <= txe_meta_q;
      rx_hold_q   <= rx_hold_d;
      rx_av_q     <= rx_av_d;
      tx_hold_q   <= tx_hold_d;
      tx_full_q   <= tx_full_d;
      tx_ovr_q    <= tx_ovr_d;
      irq_en_q    <= irq_en_d;
      nrd_q       <= nrd_d;
      wr_q        <= wr_d;
      fd_oe_q     <= fd_oe_d;
      fd_out_q    <= fd_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_tx_d = last_tx_q;
    rx_hold_d = rx_hold_q;
    rx_av_d   = rx_av_q;
    tx_hold_d = tx_hold_q;
    tx_full_d = tx_full_q;
    tx_ovr_d  = tx_ovr_q;
    irq_en_d  = irq_en_q;
    fd_out_d  = fd_out_q;
    rx_elig   = ~rx_av_q & ~nrxf_sync_q;
    tx_elig   = tx_full_q & ~txe_sync_q;

    if (WR_STB && ADDR) begin
      irq_en_d = DIN[0];
    end
    if (RD_STB && !ADDR) begin
      rx_av_d = 1'b0;
    end
    if (RD_STB && ADDR) begin
      tx_ovr_d = 1'b0;
    end
    if (WR_STB && !ADDR) begin
      if (tx_full_q) begin
        tx_ovr_d = 1'b1;
      end else begin
        tx_hold_d = DIN;
        tx_full_d = 1'b1;
      end
    end

    // FSM updates come last so a completing transfer wins over a same-cycle CPU access.
    case (state_q)
      S_IDLE: begin
        if (rx_elig && (!tx_elig || last_tx_q)) begin
          state_d   = S_RD_LOW;
          cnt_d     = CNT_W'(RD_PULSE - 1);
          last_tx_d = 1'b0;
        end else if (tx_elig) begin
          state_d   = S_WR_SETUP;
          fd_out_d  = tx_hold_q;
          tx_full_d = 1'b0;
          last_tx_d = 1'b1;
        end
      end
      S_RD_LOW: begin
        if (cnt_q == '0) begin
          rx_hold_d = FD_IN;
          rx_av_d   = 1'b1;
          state_d   = S_REC;
          cnt_d     = CNT_W'(RECOVERY - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_HIGH;
        cnt_d   = CNT_W'(WR_PULSE - 1);
      end
      S_WR_HIGH: begin
        if (cnt_q == '0) begin
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WR_HOLD: begin
        state_d = S_REC;
        cnt_d   = CNT_W'(RECOVERY - 1);
      end
      S_REC: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are decoded from the next state and registered, so pins never glitch.
    nrd_d   = (state_d != S_RD_LOW);
    wr_d    = (state_d == S_WR_HIGH);
    fd_oe_d = (state_d == S_WR_SETUP) || (state_d == S_WR_HIGH) || (state_d == S_WR_HOLD);
  end

  always_comb begin
    if (ADDR) begin
      DOUT = {rx_av_q, ~tx_full_q, 1'b0, tx_ovr_q, 3'b000, irq_en_q};
    end else begin
      DOUT = rx_hold_q;
    end
  end

  assign IRQ    = rx_av_q & irq_en_q;
  assign nRD    = nrd_q;
  assign WR     = wr_q;
  assign FD_OE  = fd_oe_q;
  assign FD_OUT = fd_out_q;

endmodule

`default_nettype wire
